rv32i_hazard_ctrl: RTL
======================

Name: rv32i_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the rv32i pipeline.
- Keeps a shadow scoreboard of in-flight destination registers for EX through WB, and selects the forwarding source for each ID operand.
- Detects load-use hazards and issues stall/bubble controls. Sequences fetch flushes after taken jumps.
- Keeps saturating stall and flush performance counters.
- Sits beside the ID stage; its outputs drive IF hold, the ID/EX bubble and the operand forwarding muxes.

Parameters:
XLEN, 32, datapath width (used for counter width)
REG_W, 5, register address width
FWD_STAGES, 3, tracked stages after ID (1=EX, 2=MEM, 3=WB); legal range 1..6
LOAD_LAT, 1, number of stages a load result is unavailable after EX entry; legal range 0..FWD_STAGES-1
FLUSH_CYCLES, 1, fetch-kill cycles after a taken jump; legal range 1..3
SEL_W, $clog2(FWD_STAGES+1), forwarding select width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a valid instruction
id_rs1  in  REG_W  ID source register 1
id_rs2  in  REG_W  ID source register 2
id_rs1_used  in  1  rs1 read by instruction
id_rs2_used  in  1  rs2 read by instruction
id_wb_en  in  1  ID instruction writes a register
id_wb_reg  in  REG_W  ID destination register
id_is_load  in  1  ID instruction is a load
jump_en  in  1  taken jump/branch resolved in ID
stall_if  out  1  hold PC and IF/ID register
bubble_ex  out  1  inject NOP into ID/EX register
flush_if  out  1  kill the instruction in IF/ID
fwd_sel_rs1  out  SEL_W  0=regfile, k=stage k result
fwd_sel_rs2  out  SEL_W  as fwd_sel_rs1
stall_count  out  XLEN  saturating count of load-use stall cycles
flush_count  out  XLEN  saturating count of flush cycles

Behaviour:
- Scoreboard: entries e[1..FWD_STAGES]; each entry is {valid, wb_en, reg, is_load}. All entries shift every cycle. There is no back-pressure downstream of ID.
- Entry e[1] load rule (next state):
  - stall or flush_if active: bubble (valid=0).
  - otherwise: captures the ID fields, with valid=id_valid.
- Match(k,r): e[k].valid & e[k].wb_en & e[k].reg==r & r!=0. Register x0 never matches.
- Load-use hazard (combinational): id_valid, and a used rs has Match(k,rs) with e[k].is_load and k<=LOAD_LAT, for any k.
- stall = hazard.
  - stall_if = stall.
  - bubble_ex = stall | flush_if.
- Forwarding: fwd_sel_rsN = the smallest k with Match(k,rsN) and not (is_load & k<=LOAD_LAT), so the youngest producer wins. Otherwise 0. If rsN is unused, the select is 0.
- Outputs are same-cycle combinational from the ID inputs and the registered scoreboard.
- Flush sequencer: states IDLE and FLUSH, with a down-counter.
  - IDLE→FLUSH when jump_en & id_valid & !stall. The counter loads FLUSH_CYCLES.
  - flush_if=1 while in FLUSH. The counter decrements each cycle; FLUSH→IDLE when it reaches 1.
  - jump_en during FLUSH is ignored, because the ID contents are being killed.
- Simultaneous events:
  - Stall and jump: stall wins. The jump is ignored and is re-presented by the held ID instruction.
  - Stall during FLUSH: cannot occur, since the ID instruction is a bubble.
- Counters:
  - stall_count increments each cycle stall=1.
  - flush_count increments each cycle flush_if=1.
  - Both saturate at all-ones.
- Reset (asynchronous): all entries invalid, state IDLE, counter 0, both counts 0. Every output is 0 during and after reset until new inputs arrive.
- A reset asserted mid-stall or mid-flush aborts it immediately.

Decomposition:
- Package rv32i_pkg holds:
  - the sb_entry_t struct {valid, wb_en, reg, is_load};
  - the REG_W constant;
  - the flush state enum {IDLE, FLUSH}.
- One sub-module, rv32i_sat_counter (parametrised width, inc input), instantiated twice for the performance counters.

Test Plan:
1. ALU chain: add x5 followed immediately by add x6,x5,x5 → fwd_sel_rs1=fwd_sel_rs2=1, no stall. One cycle later, an instruction reading x5 gets select 2; later gets 3; then 0.
2. Load-use: lw x7, then add x8,x7,x0 with LOAD_LAT=1 → stall_if=bubble_ex=1 for exactly 1 cycle, stall_count=1, then fwd_sel_rs1=2.
3. x0 destination: addi x0 followed by a read of x0 → fwd_sel=0 and no stall, even when the earlier instruction is a load to x0.
4. Jump: jump_en=1 with FLUSH_CYCLES=2 → flush_if=1 for 2 cycles, bubble_ex=1 for both, flush_count=2. A second jump_en inside the window is ignored.
5. Stall plus jump: a load-use hazard with jump_en=1 in the same cycle → stall only. The flush starts the cycle after the stall clears.
6. Reset mid-flush: assert reset in flush cycle 1 → flush_if=0 and the counters are 0 immediately. Parameter sweep FWD_STAGES=5, LOAD_LAT=2 → a load followed by a dependent instruction stalls 2 cycles.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared types for the rv32i hazard/forwarding controller: scoreboard entry
// layout, register address width and the fetch-flush sequencer states.
package rv32i_pkg;

  localparam int REG_W = 5;

  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_t;

endpackage

// File: rtl/rv32i_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module rv32i_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rv32i_hazard_ctrl.sv
// Load-use stall detection, operand forwarding select and post-jump fetch
// flush sequencing for the rv32i pipeline, driven from a shadow scoreboard.
module rv32i_hazard_ctrl #(
  parameter int XLEN         = 32,
  parameter int REG_W        = 5,
  parameter int FWD_STAGES   = 3,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int SEL_W        = $clog2(FWD_STAGES + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             id_wb_en,
  input  logic [REG_W-1:0] id_wb_reg,
  input  logic             id_is_load,
  input  logic             jump_en,
  output logic             stall_if,
  output logic             bubble_ex,
  output logic             flush_if,
  output logic [SEL_W-1:0] fwd_sel_rs1,
  output logic [SEL_W-1:0] fwd_sel_rs2,
  output logic [XLEN-1:0]  stall_count,
  output logic [XLEN-1:0]  flush_count
);

  import rv32i_pkg::sb_entry_t;
  import rv32i_pkg::flush_state_t;
  import rv32i_pkg::IDLE;
  import rv32i_pkg::FLUSH;

  sb_entry_t sb_q [1:FWD_STAGES];
  sb_entry_t sb_d [1:FWD_STAGES];

  logic [FWD_STAGES:1] match1;
  logic [FWD_STAGES:1] match2;
  logic [FWD_STAGES:1] ld_early;
  logic                stall;

  flush_state_t state_q, state_d;
  logic [1:0]   fcnt_q, fcnt_d;

  genvar gi;
  generate
    for (gi = 1; gi <= FWD_STAGES; gi++) begin : g_sb
      // Loads still inside the shadow window have no result to forward yet.
      localparam bit EARLY = (gi <= LOAD_LAT);

      assign match1[gi] = sb_q[gi].valid & sb_q[gi].wb_en &
                          (sb_q[gi].rd == id_rs1) & (id_rs1 != '0);
      assign match2[gi] = sb_q[gi].valid & sb_q[gi].wb_en &
                          (sb_q[gi].rd == id_rs2) & (id_rs2 != '0);
      assign ld_early[gi] = sb_q[gi].is_load & EARLY;

      if (gi == 1) begin : g_head
        assign sb_d[gi] = (stall | flush_if) ? sb_entry_t'('0) :
                          sb_entry_t'({id_valid, id_wb_en, id_wb_reg, id_is_load});
      end else begin : g_tail
        assign sb_d[gi] = sb_q[gi-1];
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          sb_q[gi] <= '0;
        end else begin
          sb_q[gi] <= sb_d[gi];
        end
      end
    end
  endgenerate

  assign stall = id_valid &
                 (|(((match1 & {FWD_STAGES{id_rs1_used}}) |
                     (match2 & {FWD_STAGES{id_rs2_used}})) & ld_early));

  assign stall_if  = stall;
  assign bubble_ex = stall | flush_if;

  // Scan oldest to youngest so the youngest producer overwrites the select.
  always_comb begin
    fwd_sel_rs1 = '0;
    fwd_sel_rs2 = '0;
    for (int k = FWD_STAGES; k >= 1; k--) begin
      if (id_rs1_used && match1[k] && !ld_early[k]) fwd_sel_rs1 = SEL_W'(k);
      if (id_rs2_used && match2[k] && !ld_early[k]) fwd_sel_rs2 = SEL_W'(k);
    end
  end

  always_comb begin
    state_d  = state_q;
    fcnt_d   = fcnt_q;
    flush_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (jump_en && id_valid && !stall) begin
          state_d = FLUSH;
          fcnt_d  = 2'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        flush_if = 1'b1;
        fcnt_d   = fcnt_q - 2'd1;
        if (fcnt_q == 2'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  rv32i_sat_counter #(.WIDTH(XLEN)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall),
    .count (stall_count)
  );

  rv32i_sat_counter #(.WIDTH(XLEN)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_if),
    .count (flush_count)
  );

endmodule
